fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that wraps the team's dual-port RAM. It owns the write/read pointers, occupancy and flags.
- Drives RAM port A as the write port and port B as the read port.
- Presents a valid/ready push interface upstream and a first-word-fall-through (FWFT) pop interface downstream.
- The RAM output register doubles as the FWFT output stage.

---
 rtl/fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: first-word-fall-through FIFO controller around an external dual-port RAM (A = write, B = read).
// Optional feature macro FIFO_CTRL_STICKY_ERR_EN adds the sticky overflow flag err_ovf and its clear err_clr.
module fifo_ctrl #(
  parameter int ADDR      = 4,
  parameter int DATA      = 8,
  parameter int AFULL_TH  = 2**ADDR - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clK,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic [ADDR:0]   count,
  output logic            almost_full,
  output logic            almost_empty,
`ifdef FIFO_CTRL_STICKY_ERR_EN
  output logic            err_ovf,
  input  logic            err_clr,
`endif
  output logic            ram_a_wr,
  output logic [ADDR-1:0] ram_a_addr,
  output logic [DATA-1:0] ram_a_din,
  output logic            ram_b_wr,
  output logic [ADDR-1:0] ram_b_addr,
  input  logic [DATA-1:0] ram_b_dout
);

  localparam logic [ADDR:0] DEPTH     = (ADDR+1)'(2**ADDR);
  localparam logic [0:0]    S_EMPTY   = 1'b0;
  localparam logic [0:0]    S_VALID   = 1'b1;

  logic [ADDR:0]   r_wrPtr;
  logic [ADDR:0]   r_rdPtr;
  logic [ADDR:0]   r_memCnt;
  logic [ADDR:0]   r_count;
  logic [0:0]      r_rdState;
  logic            r_almostFull;
  logic            r_almostEmpty;

  logic            w_push;
  logic            w_pop;
  logic            w_fetch;
  logic [0:0]      w_rdStateNext;
  logic [ADDR:0]   w_countNext;
  logic [ADDR:0]   w_memCntNext;
  logic [ADDR-1:0] w_rdPrev;

  // Full is judged on total occupancy so the slot shown in the output stage is never overwritten.
  assign wr_ready     = (r_count != DEPTH);
  assign w_push       = wr_valid & wr_ready;
  assign w_pop        = r_rdState[0] & rd_ready;
  assign w_fetch      = (r_memCnt != '0) & (~r_rdState[0] | rd_ready);

  assign w_countNext  = r_count + (ADDR+1)'(w_push) - (ADDR+1)'(w_pop);
  assign w_memCntNext = r_memCnt + (ADDR+1)'(w_push) - (ADDR+1)'(w_fetch);
  assign w_rdPrev     = r_rdPtr[ADDR-1:0] - ADDR'(1);

  assign ram_a_wr     = w_push;
  assign ram_a_addr   = r_wrPtr[ADDR-1:0];
  assign ram_a_din    = wr_data;
  assign ram_b_wr     = 1'b0;
  // Without a fetch, port B re-reads the displayed slot so the registered RAM output holds the head word.
  assign ram_b_addr   = w_fetch ? r_rdPtr[ADDR-1:0] : w_rdPrev;

  assign rd_data      = ram_b_dout;
  assign rd_valid     = r_rdState[0];
  assign count        = r_count;
  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;

  always_comb begin
    w_rdStateNext = r_rdState;
    case (r_rdState)
      S_EMPTY: if (w_fetch) w_rdStateNext = S_VALID;
      S_VALID: if (!w_fetch && rd_ready) w_rdStateNext = S_EMPTY;
      default: w_rdStateNext = S_EMPTY;
    endcase
  end

  always_ff @(posedge clK or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_memCnt      <= '0;
      r_count       <= '0;
      r_rdState     <= S_EMPTY;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
    end else begin
      if (w_push)  r_wrPtr <= r_wrPtr + (ADDR+1)'(1);
      if (w_fetch) r_rdPtr <= r_rdPtr + (ADDR+1)'(1);
      r_memCnt      <= w_memCntNext;
      r_count       <= w_countNext;
      r_rdState     <= w_rdStateNext;
      // Flags come from the next-state count so they are registered with no input-to-flag path.
      r_almostFull  <= (w_countNext >= (ADDR+1)'(AFULL_TH));
      r_almostEmpty <= (w_countNext <= (ADDR+1)'(AEMPTY_TH));
    end
  end

`ifdef FIFO_CTRL_STICKY_ERR_EN
  logic r_errOvf;

  assign err_ovf = r_errOvf;

  always_ff @(posedge clK or negedge rst_n) begin
    if (!rst_n) begin
      r_errOvf <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      r_errOvf <= 1'b1;
    end else if (err_clr) begin
      r_errOvf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and randomized checks of fifo_ctrl against a queue-based reference model.
// Define FIFO_CTRL_STICKY_ERR_EN to also exercise the sticky overflow flag.
module tb_fifo_ctrl;

   localparam int ADDR  = 4;
   localparam int DATA  = 8;
   localparam int DEPTH = 2**ADDR;

   logic            clK;
   logic            rst_n;
   logic            wr_valid;
   logic            wr_ready;
   logic [DATA-1:0] wr_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [DATA-1:0] rd_data;
   logic [ADDR:0]   count;
   logic            almost_full;
   logic            almost_empty;
   logic            ram_a_wr;
   logic [ADDR-1:0] ram_a_addr;
   logic [DATA-1:0] ram_a_din;
   logic            ram_b_wr;
   logic [ADDR-1:0] ram_b_addr;
   logic [DATA-1:0] ram_b_dout;
`ifdef FIFO_CTRL_STICKY_ERR_EN
   logic            err_ovf;
   logic            err_clr;
   logic            mErr;
`endif

   logic [DATA-1:0] ram [DEPTH];

   logic [DATA-1:0] memQ [$];
   logic            mValid;
   logic [DATA-1:0] mData;

   int assertCount;
   int failCount;

   fifo_ctrl #(.ADDR(ADDR), .DATA(DATA)) dut (
      .clK          (clK),
      .rst_n        (rst_n),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
`ifdef FIFO_CTRL_STICKY_ERR_EN
      .err_ovf      (err_ovf),
      .err_clr      (err_clr),
`endif
      .ram_a_wr     (ram_a_wr),
      .ram_a_addr   (ram_a_addr),
      .ram_a_din    (ram_a_din),
      .ram_b_wr     (ram_b_wr),
      .ram_b_addr   (ram_b_addr),
      .ram_b_dout   (ram_b_dout)
   );

   // Free-running clock, 10 time units per period.
   initial clK = 1'b0;
   always #5 clK = ~clK;

   // Dual-port RAM with a registered port-B read, standing in for the team RAM.
   always @(posedge clK) begin
      if (ram_a_wr) ram[ram_a_addr] <= ram_a_din;
      ram_b_dout <= ram[ram_b_addr];
   end

   // Compares one observed value with its expected value and counts the result.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Compares every visible output against the reference model state.
   task automatic checkAgainstModel();
      int cnt;
      cnt = memQ.size() + (mValid ? 1 : 0);
      checkOutput("count", 32'(count), 32'(cnt));
      checkOutput("rd_valid", 32'(rd_valid), 32'(mValid));
      checkOutput("wr_ready", 32'(wr_ready), 32'(cnt != DEPTH));
      checkOutput("almost_full", 32'(almost_full), 32'(cnt >= DEPTH - 2));
      checkOutput("almost_empty", 32'(almost_empty), 32'(cnt <= 2));
      checkOutput("ram_b_wr", 32'(ram_b_wr), 32'(0));
      if (mValid) checkOutput("rd_data", 32'(rd_data), 32'(mData));
`ifdef FIFO_CTRL_STICKY_ERR_EN
      checkOutput("err_ovf", 32'(err_ovf), 32'(mErr));
`endif
   endtask

   // Drives one cycle of inputs, advances the model by the FIFO rules, then checks at the falling edge.
   task automatic applyStimulus(input logic wv, input logic [DATA-1:0] wd, input logic rr, input logic clr);
      int  cnt;
      logic doPush;
      logic doFetch;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
`ifdef FIFO_CTRL_STICKY_ERR_EN
      err_clr  = clr;
`endif
      cnt     = memQ.size() + (mValid ? 1 : 0);
      doPush  = wv && (cnt != DEPTH);
      doFetch = (memQ.size() != 0) && (!mValid || rr);
`ifdef FIFO_CTRL_STICKY_ERR_EN
      if (wv && !doPush) mErr = 1'b1;
      else if (clr)      mErr = 1'b0;
`else
      if (clr) cnt = cnt;
`endif
      if (doFetch) begin
         mData  = memQ.pop_front();
         mValid = 1'b1;
      end else if (rr) begin
         mValid = 1'b0;
      end
      if (doPush) memQ.push_back(wd);
      @(negedge clK);
      checkAgainstModel();
   endtask

   task automatic resetModel();
      memQ.delete();
      mValid = 1'b0;
      mData  = '0;
`ifdef FIFO_CTRL_STICKY_ERR_EN
      mErr   = 1'b0;
`endif
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
`ifdef FIFO_CTRL_STICKY_ERR_EN
      err_clr  = 1'b0;
`endif
      resetModel();
      repeat (2) @(negedge clK);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_count", 32'(count), 32'(0));
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("reset_wr_ready", 32'(wr_ready), 32'(1));
      checkOutput("reset_almost_empty", 32'(almost_empty), 32'(1));
      checkOutput("reset_almost_full", 32'(almost_full), 32'(0));
      checkOutput("reset_ram_a_wr", 32'(ram_a_wr), 32'(0));

      // Three back-to-back pushes: the head shows up two edges after the first push is offered.
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      checkOutput("head_not_yet", 32'(rd_valid), 32'(0));
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
      checkOutput("head_valid", 32'(rd_valid), 32'(1));
      checkOutput("head_data", 32'(rd_data), 32'h11);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      checkOutput("count_three", 32'(count), 32'(3));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("head_hold", 32'(rd_data), 32'h11);

      // Pop all three on consecutive cycles.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pop_second", 32'(rd_data), 32'h22);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pop_third", 32'(rd_data), 32'h33);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drained_valid", 32'(rd_valid), 32'(0));
      checkOutput("drained_count", 32'(count), 32'(0));
      checkOutput("drained_aempty", 32'(almost_empty), 32'(1));

      // Fill to the brim, then offer one word too many.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      checkOutput("full_count", 32'(count), 32'(DEPTH));
      checkOutput("full_wr_ready", 32'(wr_ready), 32'(0));
      checkOutput("full_afull", 32'(almost_full), 32'(1));
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      checkOutput("overflow_count", 32'(count), 32'(DEPTH));
      checkOutput("overflow_head", 32'(rd_data), 32'hC0);
`ifdef FIFO_CTRL_STICKY_ERR_EN
      checkOutput("err_set", 32'(err_ovf), 32'(1));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("err_hold", 32'(err_ovf), 32'(1));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("err_clear", 32'(err_ovf), 32'(0));
`endif

      // Simultaneous push and pop near full across pointer wrap.
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++)
         applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 7) == 0));

      // Drain, load five words, then pulse reset asynchronously mid-cycle.
      for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      checkOutput("pre_reset_count", 32'(count), 32'(5));
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      resetModel();
      checkOutput("async_count", 32'(count), 32'(0));
      checkOutput("async_rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("async_wr_ready", 32'(wr_ready), 32'(1));
      checkOutput("async_aempty", 32'(almost_empty), 32'(1));
      checkOutput("async_afull", 32'(almost_full), 32'(0));
      @(negedge clK);
      rst_n = 1'b1;
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("post_reset_head", 32'(rd_data), 32'hA5);
      checkOutput("post_reset_count", 32'(count), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
